// File: rtl/cdr_serial_tx.sv
// Serial test-pattern transmitter for the CDR phase detector.
// Sends data words or PRBS7 at OVS clocks per bit, with optional periodic bit stretch/shrink.
module cdr_serial_tx #(
    parameter int OVS   = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             prbs_en,
    input  logic [1:0]       drift,
    input  logic [7:0]       drift_every,
    output logic             dout,
    output logic             bit_strobe,
    output logic             busy
);
    localparam int TW = $clog2(OVS + 2);
    localparam int BW = $clog2(WIDTH);
    localparam logic [TW-1:0] P_NOM    = TW'(OVS);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [TW-1:0]    r_tick_cnt;
    logic [7:0]       r_drift_cnt;
    logic [6:0]       r_lfsr;
    logic             r_is_prbs;
    logic [1:0]       r_adj;
    logic             r_dout;
    logic             r_strobe;
    logic             r_busy;

    logic [TW-1:0] w_period;
    logic          w_last_tick;
    logic          w_word_end;
    logic          w_start;
    logic          w_drift_on;
    logic [7:0]    w_cnt_inc;
    logic [6:0]    w_lfsr_next;

    // r_adj describes the bit currently on the line: 01 long, 10 short
    always_comb begin
        w_period = P_NOM;
        case (r_adj)
            2'b01:   w_period = P_NOM + TW'(1);
            2'b10:   w_period = P_NOM - TW'(1);
            default: w_period = P_NOM;
        endcase
    end

    assign w_last_tick = (r_state == SHIFT) && (r_tick_cnt == w_period - TW'(1));
    assign w_word_end  = w_last_tick && (r_bit_cnt == LAST_BIT);
    assign data_ready  = ((r_state == IDLE) || w_word_end) && !prbs_en && !rst;
    assign w_start     = ((r_state == IDLE) || w_word_end)
                         && (prbs_en || (data_valid && data_ready));
    assign w_drift_on  = (drift_every != 8'd0) && ((drift == 2'b01) || (drift == 2'b10));
    assign w_cnt_inc   = r_drift_cnt + 8'd1;
    assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_drift_cnt <= '0;
            r_lfsr      <= 7'h7F;
            r_is_prbs   <= 1'b0;
            r_adj       <= 2'b00;
            r_dout      <= 1'b0;
            r_strobe    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_start) begin
                r_state    <= SHIFT;
                r_busy     <= 1'b1;
                r_strobe   <= 1'b1;
                r_bit_cnt  <= '0;
                r_tick_cnt <= '0;
                r_is_prbs  <= prbs_en;
                if (prbs_en) begin
                    r_dout <= r_lfsr[6];
                    r_lfsr <= w_lfsr_next;
                end else begin
                    r_dout  <= data_in[WIDTH-1];
                    r_shift <= data_in << 1;
                end
            end else if (w_word_end) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_dout     <= 1'b0;
                r_bit_cnt  <= '0;
                r_tick_cnt <= '0;
            end else if (w_last_tick) begin
                r_strobe   <= 1'b1;
                r_bit_cnt  <= r_bit_cnt + BW'(1);
                r_tick_cnt <= '0;
                if (r_is_prbs) begin
                    r_dout <= r_lfsr[6];
                    r_lfsr <= w_lfsr_next;
                end else begin
                    r_dout  <= r_shift[WIDTH-1];
                    r_shift <= r_shift << 1;
                end
            end else if (r_state == SHIFT) begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end

            // An adjusted bit restarts the count, so the pattern is N nominal then one adjusted
            if (w_last_tick) begin
                if (!w_drift_on || (r_adj != 2'b00)) begin
                    r_drift_cnt <= '0;
                    r_adj       <= 2'b00;
                end else if (w_cnt_inc == drift_every) begin
                    r_drift_cnt <= '0;
                    r_adj       <= drift;
                end else begin
                    r_drift_cnt <= w_cnt_inc;
                    r_adj       <= 2'b00;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign bit_strobe = r_strobe;
    assign busy       = r_busy;

endmodule

// File: tb/tb_cdr_serial_tx.sv
// Directed bench for cdr_serial_tx with an expected-bit scoreboard.
// Every bit is checked cycle by cycle for value, length, strobe, busy and ready.
module tb_cdr_serial_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       prbs_en = 1'b0;
    logic [1:0] drift = 2'b00;
    logic [7:0] drift_every = 8'd0;
    logic       dout;
    logic       bit_strobe;
    logic       busy;

    typedef struct packed {
        logic       b;
        logic       last;
        logic [7:0] len;
    } exp_t;

    exp_t       sb[$];
    logic       obs_q[$];
    logic [6:0] m_lfsr;
    int         checks = 0;
    int         errors = 0;

    cdr_serial_tx #(.OVS(8), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .prbs_en    (prbs_en),
        .drift      (drift),
        .drift_every(drift_every),
        .dout       (dout),
        .bit_strobe (bit_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.b    = w[7-i];
            e.last = (i == 7);
            e.len  = 8'd8;
            sb.push_back(e);
        end
    endtask

    // mode 1: stretch, mode 2: shrink; every nominal bits followed by one adjusted bit
    task automatic push_prbs(input int n, input int mode, input int every);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.b    = m_lfsr[6];
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            e.last = ((i % 8) == 7);
            e.len  = 8'd8;
            if (mode != 0 && (i % (every + 1)) == every)
                e.len = (mode == 1) ? 8'd9 : 8'd7;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() == 0) return;
            e = sb.pop_front();
            for (int c = 0; c < int'(e.len); c++) begin
                if (c == 0) obs_q.push_back(dout);
                chk("strobe", bit_strobe, (c == 0));
                chk("dout", dout, e.b);
                chk("busy", busy, 1);
                chk("ready", data_ready, e.last && (c == int'(e.len) - 1) && !prbs_en);
                @(negedge clk);
            end
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_ready);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_strobe"}, bit_strobe, 0);
        chk({tag, "_ready"}, data_ready, exp_ready);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle("rst", 1'b0);
        end
        rst = 1'b0;
        m_lfsr = 7'h7F;
        #1;
    endtask

    initial begin
        logic [7:0] first8;
        m_lfsr = 7'h7F;
        @(negedge clk);

        // reset with valid held, then single word A5
        data_in    = 8'hA5;
        data_valid = 1'b1;
        do_reset();
        chk_idle("post_rst", 1'b1);
        push_word(8'hA5);
        @(negedge clk);
        data_valid = 1'b0;
        drain(8);
        chk_idle("a5_end", 1'b1);

        // back-to-back FF then 00
        data_in    = 8'hFF;
        data_valid = 1'b1;
        push_word(8'hFF);
        @(negedge clk);
        data_in = 8'h00;
        push_word(8'h00);
        drain(9);
        data_valid = 1'b0;
        drain(7);
        chk_idle("b2b_end", 1'b1);

        // PRBS from reset, 256 bits; prbs_en dropped inside the final block
        prbs_en = 1'b1;
        do_reset();
        obs_q.delete();
        push_prbs(256, 0, 0);
        @(negedge clk);
        drain(248);
        prbs_en = 1'b0;
        drain(8);
        chk_idle("prbs_end", 1'b1);
        for (int i = 0; i < 8; i++) first8[7-i] = obs_q[i];
        chk("prbs_first8", first8, 8'hFE);
        for (int i = 0; i < 127; i++)
            chk("prbs_period", obs_q[i], obs_q[i+127]);

        // drift stretch: 8,8,8,8,9
        prbs_en     = 1'b1;
        drift       = 2'b01;
        drift_every = 8'd4;
        do_reset();
        push_prbs(40, 1, 4);
        @(negedge clk);
        drain(32);
        prbs_en = 1'b0;
        drain(8);
        chk_idle("stretch_end", 1'b1);

        // drift shrink: 8,8,8,8,7
        prbs_en = 1'b1;
        drift   = 2'b10;
        do_reset();
        push_prbs(40, 2, 4);
        @(negedge clk);
        drain(32);
        prbs_en = 1'b0;
        drain(8);
        chk_idle("shrink_end", 1'b1);
        drift       = 2'b00;
        drift_every = 8'd0;

        // reset at cycle 20 of A5, then a clean 3C
        data_in    = 8'hA5;
        data_valid = 1'b1;
        push_word(8'hA5);
        @(negedge clk);
        data_valid = 1'b0;
        drain(2);
        for (int c = 0; c < 4; c++) begin
            chk("mid_dout", dout, 1);
            chk("mid_busy", busy, 1);
            @(negedge clk);
        end
        sb.delete();
        rst        = 1'b1;
        data_in    = 8'h3C;
        data_valid = 1'b1;
        #1;
        chk("rst_ready", data_ready, 0);
        @(negedge clk);
        chk_idle("mid_rst", 1'b0);
        rst = 1'b0;
        #1;
        chk_idle("mid_rel", 1'b1);
        push_word(8'h3C);
        @(negedge clk);
        data_valid = 1'b0;
        drain(8);
        chk_idle("3c_end", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
